estagio_busca: RTL and testbench
================================

# estagio_busca

Instruction-fetch stage of the 5-stage pipeline. Holds the program counter, issues one fetch per cycle to the synchronous instruction memory, and computes PC+4 with 32-bit wrap. It buffers returned instructions and presents them, with their PC and PC+4, to the decode stage through a valid/ready handshake. It also applies branch/jump redirects from execute, flushing all younger fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned).
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  fetch address (bits [1:0] always 0).
- imem_rdata  in  32  instruction; valid the cycle after the matching imem_req (fixed 1-cycle latency, no stalls).
- desvio  in  1  redirect pulse from execute.
- alvo  in  32  redirect target, sampled when desvio=1.
- id_ready  in  1  decode accepts the current instruction.
- id_valid  out  1  id_instr/id_pc/id_pc4 hold a valid instruction.
- id_instr  out  32  instruction word.
- id_pc  out  32  address of id_instr.
- id_pc4  out  32  id_pc + 4 mod 2^32.

## Operation
- Registers: pc, a fetch buffer (FIFO of {instr, pc, pc4}), one in-flight flag with its pc, and an epoch bit.
- Capacity: baseline buffer has 2 entries (output slot plus skid slot).
- Issue rule: imem_req=1 when occupancy + in_flight − (id_valid & id_ready) < capacity and desvio=0.
- When a request is issued, imem_addr=pc and pc advances to pc+4. The addition wraps: 32'hFFFF_FFFC → 32'h0000_0000.
- Return: in the cycle after an issue, imem_rdata is written to the buffer tail with the in-flight pc and pc+4.
  - The write happens only if the in-flight epoch equals the current epoch; otherwise the data is dropped.
- Handshake: the head entry drives id_*. It is popped on id_valid & id_ready. id_* are stable while id_valid=1 & id_ready=0.
- A push and a pop in the same cycle are both performed.
- Redirect (desvio=1):
  - At the edge, pc ← {alvo[31:2], 2'b00}.
  - The buffer empties.
  - The epoch toggles, so any in-flight response arriving next cycle is discarded.
  - No request is issued in the desvio cycle.
  - Redirect has priority over handshake: a same-cycle pop has no further effect.
  - desvio while id_ready=0 is legal.
  - Back-to-back desvio: the last target wins.
- Misaligned alvo: low bits are silently cleared.
- Reset (any time, including mid-fetch or mid-stall): pc ← RESET_PC, buffer empty, in-flight cleared, epoch 0.
- Output values during and immediately after reset: id_valid=0, id_instr=0, id_pc=0, id_pc4=0, imem_req=0, imem_addr=RESET_PC.

## Timing
- Sustained throughput is 1 instruction/cycle with id_ready=1.
- Fetch to decode: issue in cycle k, rdata in cycle k+1, id_valid in cycle k+2.
- After reset_n rises: imem_req=1 with imem_addr=RESET_PC in the first cycle. The first id_valid comes 2 cycles later.
- Redirect sampled in cycle r:
  - cycle r+1: imem_addr=alvo.
  - cycle r+3: id_valid with id_pc=alvo.
  - id_valid=0 in cycles r+1 and r+2.
- Stall: when id_ready drops, at most one in-flight response lands in the skid slot. No response is ever lost, and none is ever overwritten.
- Full buffer: imem_req=0 until a pop occurs. Issue resumes in the pop cycle.
- Empty buffer: id_valid=0 and id_* hold their last values.

## Configuration
- FETCH_QUEUE_EN defined: the buffer is a 4-entry circular FIFO with 2-bit pointers that wrap. This lets fetch run up to 3 instructions ahead of a stalled decode.
- Undefined: the buffer is the 2-entry output plus skid structure.
- Interface, latency, and redirect behaviour are identical in both builds; only capacity changes.

## Test plan
- Reset, then id_ready=1 and imem_rdata=pc^32'hA5A5_A5A5 → id_pc sequence 0,4,8,… from cycle 2, one per cycle, with matching id_instr and id_pc4=id_pc+4.
- Hold id_ready=0 from the cycle id_pc=8 appears, for 5 cycles:
  - Baseline: id_pc stays 8 and imem_req stops after 2 buffered entries.
  - FETCH_QUEUE_EN: 4 buffered entries.
  - Release id_ready → 8,12,16,… with no gap and no duplicate.
- desvio=1, alvo=32'h0000_0103 in a steady stream → id_valid=0 for 2 cycles, then id_pc=32'h0000_0100. The in-flight old instruction never appears.
- desvio asserted while id_ready=0 and the buffer is full → buffer flushed; next id_pc=alvo at r+3.
- RESET_PC=32'hFFFF_FFF8 → id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc4 for FFFF_FFFC is 0.
- reset_n pulsed low mid-stall with a full buffer → outputs zero immediately (async). The first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/estagio_busca.sv
// estagio_busca: instruction-fetch stage of the 5-stage pipeline.
// Holds the PC, issues one fetch per cycle to a 1-cycle-latency instruction
// memory, buffers the returned words and hands {instr, pc, pc+4} to decode
// over a valid/ready handshake. Branch/jump redirects flush younger fetches.
// Build macro FETCH_QUEUE_EN: 4-entry circular fetch queue instead of the
// default output-slot plus skid-slot pair. Interface and latency are identical.
module estagio_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        desvio,
  input  logic [31:0] alvo,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  logic [31:0] pc;
  logic        in_flight;
  logic [31:0] flight_pc;
  logic        flight_epoch;
  logic        epoch;
  logic [2:0]  occupancy;
  logic [2:0]  level;
  logic        pop;
  logic        push;
  logic [31:0] push_pc4;
  logic        unused_alvo_bits;

`ifdef FETCH_QUEUE_EN
  localparam logic [2:0] CAPACITY = 3'd4;
`else
  localparam logic [2:0] CAPACITY = 3'd2;
`endif

  // A redirect target is always forced to a word boundary, so its low bits are ignored.
  assign unused_alvo_bits = ^alvo[1:0];

  // A response is kept only if it belongs to the current epoch and no flush is happening now.
  assign pop      = id_valid & id_ready;
  assign push     = in_flight & (flight_epoch == epoch) & ~desvio;
  assign push_pc4 = flight_pc + 32'd4;

  // Issue only if the word can be guaranteed a buffer slot when it returns.
  assign level     = occupancy + {2'b00, in_flight} - {2'b00, pop};
  assign imem_req  = reset_n & ~desvio & (level < CAPACITY);
  assign imem_addr = pc;

  // PC, in-flight tracking and epoch; a redirect retargets the PC and retires the old epoch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      in_flight    <= 1'b0;
      flight_pc    <= 32'h0000_0000;
      flight_epoch <= 1'b0;
      epoch        <= 1'b0;
    end else begin
      in_flight <= imem_req;
      if (imem_req) begin
        flight_pc    <= pc;
        flight_epoch <= epoch;
      end
      if (desvio) begin
        pc    <= {alvo[31:2], 2'b00};
        epoch <= ~epoch;
      end else if (imem_req) begin
        pc <= pc + 32'd4;
      end
    end
  end

`ifdef FETCH_QUEUE_EN
  logic [31:0] q_instr [4];
  logic [31:0] q_pc    [4];
  logic [31:0] q_pc4   [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [31:0] last_instr;
  logic [31:0] last_pc;
  logic [31:0] last_pc4;

  // When the queue is empty the outputs fall back to whatever was shown last cycle.
  assign occupancy = count;
  assign id_valid  = (count != 3'd0);
  assign id_instr  = id_valid ? q_instr[rd_ptr] : last_instr;
  assign id_pc     = id_valid ? q_pc[rd_ptr]    : last_pc;
  assign id_pc4    = id_valid ? q_pc4[rd_ptr]   : last_pc4;

  // Queue storage; entries are only ever read after being written, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= flight_pc;
      q_pc4[wr_ptr]   <= push_pc4;
    end
  end

  // Pointer/count bookkeeping; a redirect empties the queue and overrides any pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      last_instr <= 32'h0000_0000;
      last_pc    <= 32'h0000_0000;
      last_pc4   <= 32'h0000_0000;
    end else begin
      last_instr <= id_instr;
      last_pc    <= id_pc;
      last_pc4   <= id_pc4;
      if (desvio) begin
        rd_ptr <= wr_ptr;
        count  <= 3'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        count <= count + {2'b00, push} - {2'b00, pop};
      end
    end
  end
`else
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc4;

  assign occupancy = {2'b00, out_valid} + {2'b00, skid_valid};
  assign id_valid  = out_valid;
  assign id_instr  = out_instr;
  assign id_pc     = out_pc;
  assign id_pc4    = out_pc4;

  // Output slot feeds decode; the skid slot catches the one response that lands during a stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_instr  <= 32'h0000_0000;
      out_pc     <= 32'h0000_0000;
      out_pc4    <= 32'h0000_0000;
      skid_valid <= 1'b0;
      skid_instr <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
      skid_pc4   <= 32'h0000_0000;
    end else if (desvio) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_instr  <= skid_instr;
        out_pc     <= skid_pc;
        out_pc4    <= skid_pc4;
        skid_valid <= push;
        if (push) begin
          skid_instr <= imem_rdata;
          skid_pc    <= flight_pc;
          skid_pc4   <= push_pc4;
        end
      end else begin
        out_valid <= push;
        if (push) begin
          out_instr <= imem_rdata;
          out_pc    <= flight_pc;
          out_pc4   <= push_pc4;
        end
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_instr <= imem_rdata;
      skid_pc    <= flight_pc;
      skid_pc4   <= push_pc4;
    end
  end
`endif

endmodule

// File: tb/tb_estagio_busca.sv
// tb_estagio_busca: scoreboard bench for estagio_busca.
// A reference PC model pushes the expected {instr, pc, pc4} whenever a fetch is
// issued; entries are popped and compared when decode accepts an instruction.
// A second instance with RESET_PC = 32'hFFFF_FFF8 exercises the PC wrap.
module tb_estagio_busca;

  localparam logic [31:0] MAGIC   = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
`ifdef FETCH_QUEUE_EN
  localparam int CAPACITY = 4;
`else
  localparam int CAPACITY = 2;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        desvio = 1'b0;
  logic [31:0] alvo = 32'h0000_0000;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata = 32'h0000_0000;
  logic        w_desvio = 1'b0;
  logic [31:0] w_alvo = 32'h0000_0000;
  logic        w_id_ready = 1'b1;
  logic        w_id_valid;
  logic [31:0] w_id_instr;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_pc4;

  exp_t        sb[$];
  logic [31:0] model_pc = 32'h0000_0000;
  logic [31:0] w_exp = WRAP_PC;
  int          w_seen = 0;
  logic        first_req_pending = 1'b0;
  int          req_count = 0;
  int          req_before = 0;
  int          check_count = 0;
  int          fail_count = 0;

  estagio_busca dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .desvio     (desvio),
    .alvo       (alvo),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4)
  );

  estagio_busca #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_req   (w_imem_req),
    .imem_addr  (w_imem_addr),
    .imem_rdata (w_imem_rdata),
    .desvio     (w_desvio),
    .alvo       (w_alvo),
    .id_ready   (w_id_ready),
    .id_valid   (w_id_valid),
    .id_instr   (w_id_instr),
    .id_pc      (w_id_pc),
    .id_pc4     (w_id_pc4)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Instruction memories: fixed 1-cycle latency, content = address ^ MAGIC.
  always @(posedge clock) begin
    imem_rdata   <= imem_req   ? (imem_addr ^ MAGIC)   : 32'hDEAD_BEEF;
    w_imem_rdata <= w_imem_req ? (w_imem_addr ^ MAGIC) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs (called at a falling edge), runs the scoreboard, then waits a cycle.
  task automatic applyStimulus(input logic rdy, input logic dv, input logic [31:0] tgt);
    exp_t e;
    id_ready = rdy;
    desvio   = dv;
    alvo     = tgt;
    #1;
    if (first_req_pending) begin
      checkOutput("first_req", 32'(imem_req), 32'd1);
      first_req_pending = 1'b0;
    end
    if (id_valid && id_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_empty_pop", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("id_instr", id_instr, e.instr);
        checkOutput("id_pc", id_pc, e.pc);
        checkOutput("id_pc4", id_pc4, e.pc4);
      end
    end
    if (imem_req) req_count++;
    if (desvio) begin
      checkOutput("req_in_desvio", 32'(imem_req), 32'd0);
      sb.delete();
      model_pc = {tgt[31:2], 2'b00};
    end else if (imem_req) begin
      checkOutput("imem_addr", imem_addr, model_pc);
      e.instr = model_pc ^ MAGIC;
      e.pc    = model_pc;
      e.pc4   = model_pc + 32'd4;
      sb.push_back(e);
      model_pc = model_pc + 32'd4;
    end
    if (w_id_valid && w_seen < 3) begin
      checkOutput("wrap_pc", w_id_pc, w_exp);
      checkOutput("wrap_pc4", w_id_pc4, w_exp + 32'd4);
      checkOutput("wrap_instr", w_id_instr, w_exp ^ MAGIC);
      w_exp = w_exp + 32'd4;
      w_seen++;
    end
    @(negedge clock);
  endtask

  // Asserts reset at a falling edge, checks the reset outputs at once, releases two cycles later.
  task automatic doReset();
    reset_n  = 1'b0;
    id_ready = 1'b0;
    desvio   = 1'b0;
    alvo     = 32'h0000_0000;
    #1;
    checkOutput("rst_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_instr", id_instr, 32'd0);
    checkOutput("rst_pc", id_pc, 32'd0);
    checkOutput("rst_pc4", id_pc4, 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);
    checkOutput("rst_wrap_req", 32'(w_imem_req), 32'd0);
    checkOutput("rst_wrap_addr", w_imem_addr, WRAP_PC);
    sb.delete();
    model_pc = 32'h0000_0000;
    w_exp = WRAP_PC;
    w_seen = 0;
    first_req_pending = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Main sequence: stream, stall, redirect, flush-while-full, reset mid-stall.
  initial begin
    @(negedge clock);
    doReset();

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("pc8_valid", 32'(id_valid), 32'd1);
    checkOutput("pc8_pc", id_pc, 32'd8);

    req_before = req_count;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(id_valid), 32'd1);
      checkOutput("stall_pc", id_pc, 32'd8);
      applyStimulus(1'b0, 1'b0, 32'd0);
    end
    checkOutput("stall_reqs", 32'(req_count - req_before), 32'(CAPACITY - 2));
    checkOutput("full_noreq", 32'(imem_req), 32'd0);

    for (int i = 0; i < 8; i++) begin
      checkOutput("release_valid", 32'(id_valid), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'd0);
    end

    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    checkOutput("redir_r1_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("redir_r2_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("redir_r3_valid", 32'(id_valid), 32'd1);
    checkOutput("redir_r3_pc", id_pc, 32'h0000_0100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("full2_noreq", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_2000);
    checkOutput("flush_r1_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("flush_r2_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("flush_r3_valid", 32'(id_valid), 32'd1);
    checkOutput("flush_r3_pc", id_pc, 32'h0000_2000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("pre_rst_valid", 32'(id_valid), 32'd1);
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("post_rst_pc", id_pc, 32'h0000_0018);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
    $finish;
  end

endmodule
